// File: rtl/julia_line_sched.sv
// julia_line_sched: spreads the pixels of one display line over NENG julia_calc
// engines, collects their iteration counts out of order, converts them to colour
// and writes them into the back half of a double-buffered line memory while the
// display side reads the front half.
module julia_line_sched #(
  parameter int NENG   = 2,
  parameter int DW     = 32,
  parameter int HWIDTH = 640,
  parameter int XW     = 10,
  parameter int YW     = 10,
  parameter int XSTEP  = 12,
  parameter int YSTEP  = 17,
  parameter int CW     = 6,
  parameter int MAXIT  = 255
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 LINE_REQ,
  input  logic [YW-1:0]        LINE_Y,
  input  logic                 SWAP,
  input  logic [DW-1:0]        CR,
  input  logic [DW-1:0]        CI,
  input  logic [1:0]           MODE,
  output logic                 BUSY,
  output logic                 LINE_DONE,
  output logic [NENG-1:0]      ENG_START,
  output logic [NENG*DW-1:0]   ENG_ZR,
  output logic [NENG*DW-1:0]   ENG_ZI,
  output logic [NENG*DW-1:0]   ENG_CR,
  output logic [NENG*DW-1:0]   ENG_CI,
  input  logic [NENG-1:0]      ENG_END,
  input  logic [NENG*DW-1:0]   ENG_NUM,
  input  logic [XW-1:0]        RD_X,
  output logic [3*CW-1:0]      RD_DATA
);

  localparam int IW   = (NENG > 1) ? $clog2(NENG) : 1;
  localparam int CNTW = XW + 1;   // counters must be able to hold HWIDTH itself

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t             state_r, state_s;
  logic               busy_r, line_done_r, front_r, wbank_r;
  logic [DW-1:0]      cr_r, ci_r, zr_acc_r, zi_r;
  logic [1:0]         mode_r;
  logic [CNTW-1:0]    next_x_r, done_cnt_r;
  logic [NENG-1:0]    start_r;
  logic [XW-1:0]      tag_r [NENG];
  logic [NENG*DW-1:0] eng_zr_r, eng_zi_r, eng_cr_r, eng_ci_r;
  logic [3*CW-1:0]    mem_r [2][HWIDTH];
  logic [3*CW-1:0]    rd_data_r;

  logic [NENG-1:0]    pend_s;
  logic               wr_en_s, disp_en_s, last_x_s, last_done_s, req_s;
  logic [IW-1:0]      wr_idx_s, disp_idx_s;
  logic [XW-1:0]      wr_tag_s;
  logic [DW-1:0]      wr_num_s;
  logic [3*CW-1:0]    wr_col_s;

  // Index of the lowest set bit; callers only use it when some bit is set.
  function automatic logic [IW-1:0] lowest_idx(input logic [NENG-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = NENG - 1; k >= 0; k--) begin
      if (v[k]) idx = IW'(k);
      else      idx = idx;
    end
    return idx;
  endfunction

  // Iteration count to packed {R,G,B}.
  function automatic logic [3*CW-1:0] colour(input logic [DW-1:0] n, input logic [1:0] m);
    logic [CW-1:0] g;
    g = n[CW+1:2];
    case (m)
      2'd0:    colour = {g, {CW{1'b0}}, {CW{1'b0}}};
      2'd1:    colour = {g, g, g};
      2'd2:    colour = {n[CW-1:0], ~n[CW-1:0], n[CW-2:0], 1'b0};
      2'd3:    colour = (n >= DW'(MAXIT)) ? {(3*CW){1'b0}} : {g, g, g};
      default: colour = {(3*CW){1'b0}};
    endcase
  endfunction

  // Arbitration: lowest finished engine gets the write port, lowest idle engine gets the next pixel
  always_comb begin
    pend_s      = start_r & ENG_END;
    wr_en_s     = |pend_s;
    wr_idx_s    = lowest_idx(pend_s);
    disp_en_s   = (state_r == S_RUN) && !(&start_r);
    disp_idx_s  = lowest_idx(~start_r);
    wr_tag_s    = tag_r[wr_idx_s];
    wr_num_s    = ENG_NUM[int'(wr_idx_s)*DW +: DW];
    wr_col_s    = colour(wr_num_s, mode_r);
    last_x_s    = (next_x_r == CNTW'(HWIDTH - 1));
    last_done_s = (done_cnt_r == CNTW'(HWIDTH - 1));
    req_s       = (state_r == S_IDLE) && LINE_REQ;
  end

  // Next-state logic: IDLE -> RUN on request, RUN -> DRAIN after last dispatch, DRAIN -> IDLE after last write
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (LINE_REQ)                   state_s = S_RUN;   else state_s = S_IDLE;
      S_RUN:   if (disp_en_s && last_x_s)      state_s = S_DRAIN; else state_s = S_RUN;
      S_DRAIN: if (wr_en_s && last_done_s)     state_s = S_IDLE;  else state_s = S_DRAIN;
      default: state_s = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Line control: request latch, bank select, pixel/result counters and status flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_r      <= 1'b0;
      line_done_r <= 1'b0;
      front_r     <= 1'b0;
      wbank_r     <= 1'b0;
      cr_r        <= '0;
      ci_r        <= '0;
      mode_r      <= 2'd0;
      next_x_r    <= '0;
      zr_acc_r    <= '0;
      zi_r        <= '0;
      done_cnt_r  <= '0;
    end else begin
      front_r     <= front_r ^ SWAP;
      line_done_r <= wr_en_s && last_done_s;
      if (req_s) begin
        busy_r     <= 1'b1;
        wbank_r    <= ~front_r;
        cr_r       <= CR;
        ci_r       <= CI;
        mode_r     <= MODE;
        next_x_r   <= '0;
        zr_acc_r   <= '0;
        zi_r       <= DW'(LINE_Y) * DW'(YSTEP);
        done_cnt_r <= '0;
      end else begin
        if (disp_en_s) begin
          next_x_r <= next_x_r + CNTW'(1);
          zr_acc_r <= zr_acc_r + DW'(XSTEP);
        end
        if (wr_en_s) begin
          done_cnt_r <= done_cnt_r + CNTW'(1);
          if (last_done_s) busy_r <= 1'b0;
        end
      end
    end
  end

  // Engine interface: start flags, pixel tags and operands held while START is high
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      start_r  <= '0;
      eng_zr_r <= '0;
      eng_zi_r <= '0;
      eng_cr_r <= '0;
      eng_ci_r <= '0;
      for (int k = 0; k < NENG; k++) tag_r[k] <= '0;
    end else begin
      for (int k = 0; k < NENG; k++) begin
        if (wr_en_s && (wr_idx_s == IW'(k))) begin
          start_r[k] <= 1'b0;
        end else if (disp_en_s && (disp_idx_s == IW'(k))) begin
          start_r[k]           <= 1'b1;
          tag_r[k]             <= next_x_r[XW-1:0];
          eng_zr_r[k*DW +: DW] <= zr_acc_r;
          eng_zi_r[k*DW +: DW] <= zi_r;
          eng_cr_r[k*DW +: DW] <= cr_r;
          eng_ci_r[k*DW +: DW] <= ci_r;
        end
      end
    end
  end

  // Back-bank result write port (memory contents survive reset)
  always_ff @(posedge CLK) begin
    if (wr_en_s) mem_r[wbank_r][wr_tag_s] <= wr_col_s;
  end

  // Front-bank display read port, one cycle latency
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rd_data_r <= '0;
    else        rd_data_r <= mem_r[front_r][RD_X];
  end

  assign BUSY      = busy_r;
  assign LINE_DONE = line_done_r;
  assign ENG_START = start_r;
  assign ENG_ZR    = eng_zr_r;
  assign ENG_ZI    = eng_zi_r;
  assign ENG_CR    = eng_cr_r;
  assign ENG_CI    = eng_ci_r;
  assign RD_DATA   = rd_data_r;

endmodule

// File: tb/tb_julia_line_sched.sv
// Bench for julia_line_sched: stub engines with programmable latency, a dispatch
// monitor, and a bank-content reference model checked through the read port.
module tb_julia_line_sched;
  localparam int NENG = 2, DW = 32, HW = 8, XW = 3, YW = 10;
  localparam int XSTEP = 12, YSTEP = 17, CW = 6, MAXIT = 255;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0, LINE_REQ = 1'b0, SWAP = 1'b0;
  logic [YW-1:0]     LINE_Y = '0;
  logic [DW-1:0]     CR = '0, CI = '0;
  logic [1:0]        MODE = 2'd0;
  logic [XW-1:0]     RD_X = '0;
  logic              BUSY, LINE_DONE;
  logic [NENG-1:0]   ENG_START, eng_end;
  logic [NENG*DW-1:0] ENG_ZR, ENG_ZI, ENG_CR, ENG_CI, eng_num;
  logic [3*CW-1:0]   RD_DATA;

  julia_line_sched #(.NENG(NENG), .DW(DW), .HWIDTH(HW), .XW(XW), .YW(YW), .XSTEP(XSTEP),
                     .YSTEP(YSTEP), .CW(CW), .MAXIT(MAXIT)) dut (
    .CLK(CLK), .RST_N(RST_N), .LINE_REQ(LINE_REQ), .LINE_Y(LINE_Y), .SWAP(SWAP),
    .CR(CR), .CI(CI), .MODE(MODE), .BUSY(BUSY), .LINE_DONE(LINE_DONE),
    .ENG_START(ENG_START), .ENG_ZR(ENG_ZR), .ENG_ZI(ENG_ZI), .ENG_CR(ENG_CR), .ENG_CI(ENG_CI),
    .ENG_END(eng_end), .ENG_NUM(eng_num), .RD_X(RD_X), .RD_DATA(RD_DATA));

  always #5 CLK = ~CLK;

  int n_pass = 0, n_chk = 0;
  int lat [NENG];
  int num_tab [HW];
  int cnt [NENG];

  // model state (owned by the main initial block)
  logic        front_m, wbank_m;
  logic [17:0] bank_m [2][HW];
  logic        valid_m [2];
  int          line_id = 0, exp_zi = 0, cur_mode = 0;
  logic [DW-1:0] exp_cr = '0, exp_ci = '0;
  logic        mon_en = 1'b0;

  // monitor state (owned by the monitor)
  int seen_id = 0, mon_disp = 0, mon_done = 0, mon_crci_bad = 0, mon_low_bad = 0;
  int mon_prio_bad = 0, mon_prio_evt = 0;
  int dl_x [2*HW], dl_zi [2*HW];
  logic [NENG-1:0] prev_start = '0, prev_end = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [17:0] col_ref(input int n, input int m);
    int g, lo, r;
    g  = (n / 4) % 64;
    lo = n % 64;
    case (m)
      0:       r = g * 4096;
      1:       r = g * 4096 + g * 64 + g;
      2:       r = lo * 4096 + (63 - lo) * 64 + (n % 32) * 2;
      default: r = (n >= MAXIT) ? 0 : g * 4096 + g * 64 + g;
    endcase
    return 18'(r);
  endfunction

  // stub engine latency counters
  always @(posedge CLK) begin
    for (int k = 0; k < NENG; k++) begin
      if (!ENG_START[k]) cnt[k] <= 0;
      else               cnt[k] <= cnt[k] + 1;
    end
  end

  // stub engine outputs: NUM looked up from the pixel index implied by ZR
  always_comb begin
    eng_end = '0;
    eng_num = '0;
    for (int k = 0; k < NENG; k++) begin
      int xi;
      xi = int'(ENG_ZR[k*DW +: DW]) / XSTEP;
      eng_end[k] = ENG_START[k] && (cnt[k] >= lat[k]);
      eng_num[k*DW +: DW] = (xi >= 0 && xi < HW) ? DW'(num_tab[xi]) : '0;
    end
  end

  // dispatch/write-priority monitor, sampled on the falling edge
  always @(negedge CLK) begin
    logic [NENG-1:0] pend, low1, lowmask;
    int zr;
    if (line_id != seen_id) begin
      seen_id = line_id; mon_disp = 0; mon_done = 0; mon_crci_bad = 0;
      mon_low_bad = 0; mon_prio_bad = 0; mon_prio_evt = 0;
    end else if (mon_en) begin
      pend = prev_start & prev_end;
      if (pend != '0) begin
        low1 = pend & (~pend + NENG'(1));
        if ((ENG_START & pend) != (pend & ~low1)) mon_prio_bad++;
        if (pend != low1) mon_prio_evt++;
      end
      for (int k = 0; k < NENG; k++) begin
        if (ENG_START[k] && !prev_start[k]) begin
          lowmask = NENG'((1 << k) - 1);
          if ((prev_start & lowmask) != lowmask) mon_low_bad++;
          if (ENG_CR[k*DW +: DW] != exp_cr || ENG_CI[k*DW +: DW] != exp_ci) mon_crci_bad++;
          zr = int'(ENG_ZR[k*DW +: DW]);
          if (mon_disp < 2*HW) begin
            dl_x[mon_disp]  = (zr % XSTEP == 0) ? zr / XSTEP : -1;
            dl_zi[mon_disp] = int'(ENG_ZI[k*DW +: DW]);
          end
          mon_disp++;
        end
      end
      if (LINE_DONE) mon_done++;
    end
    prev_start = ENG_START;
    prev_end   = eng_end;
  end

  task automatic start_line(input int y, input int m, input logic [DW-1:0] cr, input logic [DW-1:0] ci);
    line_id++;
    exp_zi = y * YSTEP; exp_cr = cr; exp_ci = ci; cur_mode = m;
    wbank_m = ~front_m;
    LINE_REQ = 1'b1; LINE_Y = YW'(y); CR = cr; CI = ci; MODE = 2'(m);
    @(posedge CLK); #1;
    LINE_REQ = 1'b0;
    check("busy_rise", BUSY, 1);
  endtask

  task automatic wait_line(input int swap_at, input int need_both);
    int got = 0;
    for (int c = 0; c < 400 && got == 0; c++) begin
      if (c == swap_at) SWAP = 1'b1;
      @(posedge CLK); #1;
      if (SWAP) begin SWAP = 1'b0; front_m = ~front_m; end
      if (LINE_DONE) begin got = 1; check("busy_at_done", BUSY, 0); end
    end
    check("line_done_seen", got, 1);
    @(posedge CLK); #1;
    check("done_is_pulse", LINE_DONE, 0);
    check("busy_after", BUSY, 0);
    check("done_pulses", mon_done, 1);
    check("disp_count", mon_disp, HW);
    for (int i = 0; i < HW && i < mon_disp; i++) begin
      check("disp_x", dl_x[i], i);
      check("disp_zi", dl_zi[i], exp_zi);
    end
    check("disp_crci", mon_crci_bad, 0);
    check("disp_lowest", mon_low_bad, 0);
    check("wr_prio", mon_prio_bad, 0);
    if (need_both != 0) check("both_end_seen", mon_prio_evt > 0, 1);
    for (int x = 0; x < HW; x++) bank_m[wbank_m][x] = col_ref(num_tab[x], cur_mode);
    valid_m[wbank_m] = 1'b1;
  endtask

  task automatic do_swap();
    SWAP = 1'b1;
    @(posedge CLK); #1;
    SWAP = 1'b0;
    front_m = ~front_m;
  endtask

  task automatic read_px(input int x, output logic [17:0] d);
    RD_X = XW'(x);
    @(posedge CLK); #1;
    d = RD_DATA;
  endtask

  task automatic show_check(input string tag);
    logic [17:0] d;
    if (valid_m[front_m]) begin
      for (int x = 0; x < HW; x++) begin
        read_px(x, d);
        check(tag, d, bank_m[front_m][x]);
      end
    end
  endtask

  // bring the new line to the front, verify it, then verify the older bank too
  task automatic finish_line();
    if (front_m != wbank_m) do_swap();
    show_check("rd_new");
    do_swap();
    show_check("rd_old");
  endtask

  initial begin
    logic [17:0] d;
    front_m = 1'b0; valid_m[0] = 1'b0; valid_m[1] = 1'b0;
    lat[0] = 3; lat[1] = 3;
    for (int x = 0; x < HW; x++) num_tab[x] = x * 4;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_done", LINE_DONE, 0);
    check("rst_start", ENG_START, 0);
    check("rst_zr", ENG_ZR, 0);
    check("rst_rd", RD_DATA, 0);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    mon_en = 1'b1;

    // fixed latency 3, NUM = x*4, red-only colour
    start_line(0, 0, 32'd100, 32'd200);
    wait_line(-1, 0);
    if (front_m != wbank_m) do_swap();
    read_px(5, d);
    check("mode0_red5", d, {6'd5, 12'd0});
    finish_line();

    // out-of-order completion
    lat[0] = 7; lat[1] = 2;
    for (int x = 0; x < HW; x++) num_tab[x] = int'($urandom_range(0, 255));
    start_line(100, 1, $urandom, $urandom);
    wait_line(-1, 0);
    finish_line();

    // both engines finish on the same cycle
    lat[0] = 3; lat[1] = 2;
    for (int x = 0; x < HW; x++) num_tab[x] = 4 * x + 1;
    start_line(7, 0, 32'd5, 32'd6);
    wait_line(-1, 1);
    finish_line();

    // swap mid-line, line 3
    lat[0] = 4; lat[1] = 5;
    for (int x = 0; x < HW; x++) num_tab[x] = int'($urandom_range(0, 255));
    start_line(3, 1, 32'd11, 32'd22);
    check("zi_line3", exp_zi, 51);
    wait_line(5, 0);
    check("swap_front_is_wbank", front_m == wbank_m, 1);
    finish_line();

    // MODE 3 saturation and grey
    lat[0] = 2; lat[1] = 3;
    for (int x = 0; x < HW; x++) num_tab[x] = (x % 2 == 0) ? 255 : 16;
    start_line(20, 3, 32'd1, 32'd2);
    wait_line(-1, 0);
    if (front_m != wbank_m) do_swap();
    read_px(0, d);
    check("mode3_max", d, 18'h00000);
    read_px(1, d);
    check("mode3_grey", d, {6'd4, 6'd4, 6'd4});
    finish_line();

    // MODE 2 bit mix
    for (int x = 0; x < HW; x++) num_tab[x] = 5;
    start_line(30, 2, 32'd3, 32'd4);
    wait_line(-1, 0);
    if (front_m != wbank_m) do_swap();
    read_px(0, d);
    check("mode2_mix", d, {6'd5, 6'd58, 6'd10});
    finish_line();

    // asynchronous reset in the middle of a line, then a normal line
    RD_X = XW'(3);
    for (int x = 0; x < HW; x++) num_tab[x] = int'($urandom_range(0, 300));
    lat[0] = 5; lat[1] = 5;
    start_line(10, 1, 32'd9, 32'd9);
    repeat (4) @(posedge CLK);
    #3;
    mon_en = 1'b0;
    RST_N = 1'b0;
    #1;
    check("arst_start", ENG_START, 0);
    check("arst_busy", BUSY, 0);
    check("arst_rd", RD_DATA, 0);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    valid_m[wbank_m] = 1'b0;
    front_m = 1'b0;
    mon_en = 1'b1;
    start_line(12, 1, 32'd7, 32'd8);
    wait_line(-1, 0);
    finish_line();

    // randomized lines
    for (int t = 0; t < 6; t++) begin
      int sw;
      lat[0] = int'($urandom_range(1, 8));
      lat[1] = int'($urandom_range(1, 8));
      for (int x = 0; x < HW; x++) num_tab[x] = int'($urandom_range(0, 300));
      sw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      start_line(int'($urandom_range(0, 479)), int'($urandom_range(0, 3)), $urandom, $urandom);
      wait_line(sw, 0);
      finish_line();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
